// File: rtl/booth_arith_pkg.sv
// booth_arith_pkg
//   Shared definitions for the sequential arithmetic units (Booth multiplier
//   and restoring divider).
//   - arith_state_e : common IDLE / CALC / FIX sequencing states
//   - clog2()       : width helper for iteration counters
package booth_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } arith_state_e;

  // Smallest number of bits able to index 'value' distinct states,
  // usable in constant (parameter) context.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << bits) < value) begin
        bits = bits + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/booth_div_twos_mag.sv
// twos_mag
//   WIDTH-bit conditional two's-complement negate. Used as abs() on the way
//   in (negate_i = operand sign) and as sign restore on the way out.
//   Ports:
//     value_i  in  WIDTH  value to pass through or negate
//     negate_i in  1      1 = output the two's-complement negation
//     result_o out WIDTH  value_i or -value_i (wraps for the most negative value)
module twos_mag #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] result_o
);

  // The most negative value maps onto itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1), so no extra bit is needed.
  assign result_o = negate_i ? ((~value_i) + {{(WIDTH-1){1'b0}}, 1'b1}) : value_i;

endmodule

// File: rtl/booth_div.sv
// booth_div
//   Sequential signed integer divider. Restoring division on operand
//   magnitudes, one iteration per clock, followed by a sign-correction cycle.
//   Quotient truncates toward zero, remainder takes the sign of the dividend.
//   Ports:
//     clk, rst       clock (rising edge) and synchronous active-high reset
//     start          request, only sampled in IDLE
//     dividend_i     signed dividend, sampled with start
//     divisor_i      signed divisor, sampled with start
//     busy_o         high from the cycle after acceptance until done_o
//     done_o         one-cycle result-valid pulse
//     quotient_o     signed quotient, held until overwritten by the next result
//     remainder_o    signed remainder, held likewise
//     div_by_zero_o  divisor was zero (quotient -1, remainder = dividend)
//     overflow_o     -2^(W-1) / -1 case; quotient wraps to -2^(W-1)
module booth_div
  import booth_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  arith_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_out_q, dbz_out_d;
  logic             ovf_out_q, ovf_out_d;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic             keep;

  twos_mag #(.WIDTH(WIDTH)) u_abs_dividend (
    .value_i  (dividend_i),
    .negate_i (dividend_i[WIDTH-1]),
    .result_o (dividend_mag)
  );

  twos_mag #(.WIDTH(WIDTH)) u_abs_divisor (
    .value_i  (divisor_i),
    .negate_i (divisor_i[WIDTH-1]),
    .result_o (divisor_mag)
  );

  twos_mag #(.WIDTH(WIDTH)) u_fix_quotient (
    .value_i  (quo_q),
    .negate_i (neg_quo_q),
    .result_o (quo_fixed)
  );

  twos_mag #(.WIDTH(WIDTH)) u_fix_remainder (
    .value_i  (rem_q[WIDTH-1:0]),
    .negate_i (neg_rem_q),
    .result_o (rem_fixed)
  );

  // One restoring step: shift the next dividend bit into the partial
  // remainder and trial-subtract the divisor magnitude. The shifted value is
  // always below 2^(WIDTH+1), so the top bit of the wider difference is a
  // reliable borrow indicator. A zero divisor always "fits", which naturally
  // yields an all-ones quotient and the dividend magnitude as remainder.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {2'b00, dmag_q};
    keep   = ~trial[WIDTH+1];
  end

  // Next-state logic for the IDLE -> CALC -> FIX sequence. Operand signs and
  // special-case flags are captured at acceptance so later operand changes
  // cannot disturb an operation in flight. Results are only written in FIX,
  // so they stay stable until the next divide completes.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_out_d   = dbz_out_q;
    ovf_out_d   = ovf_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          count_d   = '0;
          rem_d     = '0;
          quo_d     = dividend_mag;
          dmag_d    = divisor_mag;
          neg_quo_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
          neg_rem_d = dividend_i[WIDTH-1];
          dbz_d     = (divisor_i == '0);
          ovf_d     = (dividend_i == MIN_VAL) && (divisor_i == '1);
          busy_d    = 1'b1;
        end
      end
      CALC: begin
        rem_d   = keep ? trial[WIDTH:0] : rem_sh[WIDTH:0];
        quo_d   = {quo_q[WIDTH-2:0], keep};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = dbz_q ? '1 : quo_fixed;
        remainder_d = rem_fixed;
        dbz_out_d   = dbz_q;
        ovf_out_d   = ovf_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts any
  // divide in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_out_q   <= dbz_out_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_out_q;
  assign overflow_o    = ovf_out_q;

endmodule
